// File: rtl/decoder_n_seq_if.sv
// Control and decode-result bundle for decoder_n_seq.
// The master drives the controls and observes y/idx/wrap.
interface decoder_n_seq_if #(
  parameter int N  = 2,
  parameter int DW = 4
);
  logic               en;
  logic               mode;
  logic [N-1:0]       a;
  logic [DW-1:0]      dwell;
  logic [(1<<N)-1:0]  y;
  logic [N-1:0]       idx;
  logic               wrap;

  modport master (output en, mode, a, dwell, input  y, idx, wrap);
  modport slave  (input  en, mode, a, dwell, output y, idx, wrap);
endinterface

// File: rtl/decoder_n_seq.sv
// Registered N-to-2^N one-hot decoder.
// DIRECT decodes a; SCAN walks the active line with a programmable dwell.
module decoder_n_seq #(
  parameter int N          = 2,
  parameter int DW         = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  decoder_n_seq_if.slave  bus
);
  localparam int            L     = 1 << N;
  localparam logic [L-1:0]  ONE   = L'(1);
  // XOR with INACT applies the output polarity to a one-hot vector.
  localparam logic [L-1:0]  INACT = ACTIVE_LOW ? {L{1'b1}} : {L{1'b0}};

  typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_t;

  state_t          state_q, state_d;
  logic [L-1:0]    y_q;
  logic [N-1:0]    idx_q, idx_nx;
  logic [DW-1:0]   cnt_q;
  logic            wrap_q;

  always_comb begin
    state_d = S_IDLE;
    if (bus.en) state_d = bus.mode ? S_SCAN : S_DIRECT;
  end

  assign idx_nx = idx_q + N'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= INACT;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      case (state_d)
        S_DIRECT: begin
          idx_q <= bus.a;
          y_q   <= INACT ^ (ONE << bus.a);
        end
        S_SCAN: begin
          if (state_q != S_SCAN) begin
            idx_q <= bus.a;
            y_q   <= INACT ^ (ONE << bus.a);
          end else if (cnt_q >= bus.dwell) begin
            // dwell is live: lowering it below cnt forces an advance here
            idx_q  <= idx_nx;
            y_q    <= INACT ^ (ONE << idx_nx);
            wrap_q <= &idx_q;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
        default: y_q <= INACT;
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_n_seq.sv
// Bench for decoder_n_seq: active-high and active-low instances driven in
// lockstep, expectations queued at drive time and popped after the edge.
module tb_decoder_n_seq;
  logic clk, rst;

  decoder_n_seq_if #(.N(2), .DW(4)) bh ();
  decoder_n_seq_if #(.N(2), .DW(4)) bl ();

  decoder_n_seq #(.N(2), .DW(4), .ACTIVE_LOW(1'b0)) u_hi (.clk(clk), .rst(rst), .bus(bh));
  decoder_n_seq #(.N(2), .DW(4), .ACTIVE_LOW(1'b1)) u_lo (.clk(clk), .rst(rst), .bus(bl));

  assign bl.en    = bh.en;
  assign bl.mode  = bh.mode;
  assign bl.a     = bh.a;
  assign bl.dwell = bh.dwell;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] y;
    logic [1:0] idx;
    logic       w;
    string      nm;
  } exp_t;

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] a;
    logic [3:0] dwell;
    logic [3:0] y;
    logic [1:0] idx;
    logic       w;
    string      nm;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[17];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic e, input logic m, input logic [1:0] aa,
                              input logic [3:0] dd, input logic [3:0] ey,
                              input logic [1:0] ei, input logic ew, input string nm);
    vec_t v;
    v.en = e; v.mode = m; v.a = aa; v.dwell = dd;
    v.y = ey; v.idx = ei; v.w = ew; v.nm = nm;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.nm, ".y"},        {4'b0, bh.y},    {4'b0, e.y});
    cmp({e.nm, ".idx"},      {6'b0, bh.idx},  {6'b0, e.idx});
    cmp({e.nm, ".wrap"},     {7'b0, bh.wrap}, {7'b0, e.w});
    cmp({e.nm, ".y_lo"},     {4'b0, bl.y},    {4'b0, ~e.y});
    cmp({e.nm, ".idx_lo"},   {6'b0, bl.idx},  {6'b0, e.idx});
    cmp({e.nm, ".wrap_lo"},  {7'b0, bl.wrap}, {7'b0, e.w});
  endtask

  task automatic push(input logic [3:0] ey, input logic [1:0] ei, input logic ew, input string nm);
    exp_t e;
    e.y = ey; e.idx = ei; e.w = ew; e.nm = nm;
    sb.push_back(e);
  endtask

  // Drive controls, queue the result expected after the next edge, then check.
  task automatic apply(input logic e, input logic m, input logic [1:0] aa, input logic [3:0] dd,
                       input logic [3:0] ey, input logic [1:0] ei, input logic ew, input string nm);
    bh.en = e; bh.mode = m; bh.a = aa; bh.dwell = dd;
    push(ey, ei, ew, nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 2'd0, 4'd0, 4'b0001, 2'd0, 1'b0, "dir_a0");
    tbl[1]  = mk(1'b1, 1'b0, 2'd1, 4'd0, 4'b0010, 2'd1, 1'b0, "dir_a1");
    tbl[2]  = mk(1'b1, 1'b0, 2'd2, 4'd0, 4'b0100, 2'd2, 1'b0, "dir_a2");
    tbl[3]  = mk(1'b1, 1'b0, 2'd3, 4'd0, 4'b1000, 2'd3, 1'b0, "dir_a3");
    tbl[4]  = mk(1'b1, 1'b1, 2'd2, 4'd0, 4'b0100, 2'd2, 1'b0, "scan0_entry");
    tbl[5]  = mk(1'b1, 1'b1, 2'd0, 4'd0, 4'b1000, 2'd3, 1'b0, "scan0_s1");
    tbl[6]  = mk(1'b1, 1'b1, 2'd0, 4'd0, 4'b0001, 2'd0, 1'b1, "scan0_wrap");
    tbl[7]  = mk(1'b1, 1'b1, 2'd0, 4'd0, 4'b0010, 2'd1, 1'b0, "scan0_s3");
    tbl[8]  = mk(1'b1, 1'b1, 2'd0, 4'd0, 4'b0100, 2'd2, 1'b0, "scan0_s4");
    tbl[9]  = mk(1'b0, 1'b1, 2'd0, 4'd0, 4'b0000, 2'd2, 1'b0, "idle_hold");
    tbl[10] = mk(1'b1, 1'b1, 2'd3, 4'd2, 4'b1000, 2'd3, 1'b0, "scan2_entry");
    tbl[11] = mk(1'b1, 1'b1, 2'd1, 4'd2, 4'b1000, 2'd3, 1'b0, "scan2_h1");
    tbl[12] = mk(1'b1, 1'b1, 2'd1, 4'd2, 4'b1000, 2'd3, 1'b0, "scan2_h2");
    tbl[13] = mk(1'b1, 1'b1, 2'd1, 4'd2, 4'b0001, 2'd0, 1'b1, "scan2_wrap");
    tbl[14] = mk(1'b1, 1'b1, 2'd1, 4'd2, 4'b0001, 2'd0, 1'b0, "scan2_h4");
    tbl[15] = mk(1'b1, 1'b1, 2'd1, 4'd2, 4'b0001, 2'd0, 1'b0, "scan2_h5");
    tbl[16] = mk(1'b1, 1'b1, 2'd1, 4'd2, 4'b0010, 2'd1, 1'b0, "scan2_adv");

    // Reset with SCAN requested: outputs settle with no clock edge.
    rst = 1'b1; bh.en = 1'b1; bh.mode = 1'b1; bh.a = 2'd2; bh.dwell = 4'd0;
    #1;
    push(4'b0000, 2'd0, 1'b0, "rst_noclk");
    check_out();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      push(4'b0000, 2'd0, 1'b0, "rst_held");
      check_out();
    end
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      apply(tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].dwell,
            tbl[i].y, tbl[i].idx, tbl[i].w, tbl[i].nm);

    // Mid-dwell: with dwell=5 hold until cnt=4, then drop dwell to 1.
    for (int i = 0; i < 4; i++)
      apply(1'b1, 1'b1, 2'd3, 4'd5, 4'b0010, 2'd1, 1'b0, "dw5_hold");
    apply(1'b1, 1'b1, 2'd3, 4'd1, 4'b0100, 2'd2, 1'b0, "dw_drop_adv");
    apply(1'b0, 1'b1, 2'd3, 4'd1, 4'b0000, 2'd2, 1'b0, "dw_en_off");
    apply(1'b1, 1'b0, 2'd1, 4'd1, 4'b0010, 2'd1, 1'b0, "dw_en_on_dir");

    // SCAN -> DIRECT mid-dwell, then re-entry recaptures a.
    apply(1'b1, 1'b1, 2'd2, 4'd3, 4'b0100, 2'd2, 1'b0, "sw_scan_entry");
    apply(1'b1, 1'b1, 2'd0, 4'd3, 4'b0100, 2'd2, 1'b0, "sw_scan_hold");
    apply(1'b1, 1'b0, 2'd3, 4'd3, 4'b1000, 2'd3, 1'b0, "sw_to_direct");
    apply(1'b1, 1'b1, 2'd0, 4'd0, 4'b0001, 2'd0, 1'b0, "sw_reentry");
    apply(1'b1, 1'b1, 2'd3, 4'd0, 4'b0010, 2'd1, 1'b0, "sw_adv");

    // Reset mid-scan between edges.
    #2;
    rst = 1'b1;
    bh.a = 2'd1;
    #1;
    push(4'b0000, 2'd0, 1'b0, "rst_midscan");
    check_out();
    @(posedge clk);
    #1;
    push(4'b0000, 2'd0, 1'b0, "rst_midscan_held");
    check_out();
    rst = 1'b0;
    apply(1'b1, 1'b1, 2'd1, 4'd0, 4'b0010, 2'd1, 1'b0, "post_rst_entry");
    apply(1'b1, 1'b1, 2'd3, 4'd0, 4'b0100, 2'd2, 1'b0, "post_rst_adv");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_n_seq.md
Name: decoder_n_seq

Overview:
Parametrised, registered N-to-2^N one-hot decoder that generalises the 2-to-4 decoder.
- DIRECT mode decodes the input address with one cycle of latency.
- SCAN mode walks the one-hot output through every line on its own, holding each line for a programmable dwell time.
- Used as a select/strobe generator for banked peripherals and for LED/row scanning.

Parameters:
N, 2, address width; output width is 2^N.
DW, 4, width of the dwell-count input.
ACTIVE_LOW, 0, 1 inverts every y bit at the output; "active" and "inactive" below mean after this inversion.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  block enable; 0 forces IDLE
mode  input  1  0 = DIRECT, 1 = SCAN
a  input  N  DIRECT: address to decode; SCAN: start index, captured on SCAN entry
dwell  input  DW  SCAN: number of extra cycles each line is held (0 = advance every cycle)
y  output  2^N  registered one-hot (or all-inactive) decode
idx  output  N  registered index of the active y line
wrap  output  1  one-cycle pulse when SCAN wraps from index 2^N-1 to 0

Behaviour:
- Reset (async, rst=1): state=IDLE, y all inactive, idx=0, wrap=0, dwell counter cnt=0. Outputs change immediately, with no clock needed. On rst release, the first update is at the next posedge.
- State register has three states: IDLE, DIRECT, SCAN. Next state is evaluated on every posedge from en and mode:
  - en=0 -> IDLE
  - en=1, mode=0 -> DIRECT
  - en=1, mode=1 -> SCAN
  - Any state can reach any state in one cycle.
- IDLE:
  - y all inactive, wrap=0, cnt=0; idx holds its last value.
- DIRECT:
  - At each posedge, idx<=a and y<=onehot(a).
  - Latency is 1 cycle from a to y. wrap=0, cnt=0.
- SCAN entry (previous state not SCAN):
  - idx<=a, y<=onehot(a), cnt<=0, wrap<=0.
  - The start line is visible 1 cycle after entry.
- SCAN steady state, at each posedge:
  - If cnt >= dwell: cnt<=0, idx<=idx+1 (mod 2^N), y<=onehot(idx+1), wrap<=(idx==2^N-1).
  - Otherwise: cnt<=cnt+1, idx and y hold, wrap<=0.
  - Each line is active for exactly dwell+1 cycles. wrap is high for exactly one cycle, the first cycle line 0 is active after a wrap.
  - dwell is compared live each cycle. Lowering dwell below the current cnt forces an advance on the next posedge. cnt never overflows because it is cleared at >= dwell.
  - Input a is ignored while in SCAN.
- Mode switch SCAN->DIRECT: the next cycle shows onehot(a); cnt is cleared.
- Returning to SCAN always re-enters via the entry rule (re-captures a).
- y is always either exactly one active bit (DIRECT/SCAN) or all inactive (IDLE/reset). It never has two active bits or glitches from a register.
- Reset asserted mid-scan: all outputs return to reset values immediately; the scan does not resume after release unless en=1, mode=1 (which re-enters SCAN and captures a).
- Arithmetic: idx increment is N-bit with natural wrap; cnt is DW bits, unsigned compare.

Test Plan:
- Reset: hold rst=1 with en=1, mode=1 -> y=4'b0000, idx=0, wrap=0 throughout; y responds to rst without a clock edge.
- DIRECT (N=2, ACTIVE_LOW=0): en=1, mode=0, apply a=0,1,2,3 on successive cycles -> y=0001,0010,0100,1000 each one cycle later, idx=a delayed by 1, wrap=0.
- SCAN dwell=0 from a=2: en=1, mode=1 -> y sequence 0100,1000,0001,0010,0100…; wrap=1 only in the cycle y becomes 0001.
- SCAN dwell=2 from a=3: each line is held 3 cycles; y=1000 x3, then 0001 x3 with wrap=1 on the first of those only.
- Mid-dwell changes: in SCAN with dwell=5 and cnt=4, drop dwell to 1 -> advance on the next posedge. Then clear en -> y=0000 next cycle, idx held. Set en=1 with a=1 -> y=0010 after 1 cycle.
- ACTIVE_LOW=1: repeat the DIRECT sweep -> y=1110,1101,1011,0111; IDLE and reset give y=1111.
